mips_rtype_issuer: RTL and testbench

Register-file initiator for the R-type single-cycle MIPS datapath. Accepts one R-type instruction word at a time over a valid/ready handshake, reads rs/rt from `mips_registers` through its read ports, computes the R-type result, and writes it back to rd through the write port. It lets the register file be driven and checked end-to-end without the full datapath. It is the active end of the `mips_registers` interface.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/mips_rtype_alu.sv | 42 ++++
 rtl/mips_rtype_issuer.sv | 151 +++++++++++++++
 tb/tb_mips_rtype_issuer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the R-type issuer: instruction field positions,
// opcode/funct codes and the issuer state encoding.
package mips_pkg;

  // Instruction field positions (LSB of each field) and widths.
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int REG_W      = 5;
  localparam int OP_W       = 6;

  // Opcode of every R-type instruction.
  localparam logic [5:0] OP_RTYPE = 6'h00;

  // Supported funct codes.
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/mips_rtype_alu.sv
// Combinational R-type ALU.
// Ports:
//   i_a, i_b      : operands (rs value, rt value)
//   i_shamt       : shift amount for sll/srl/sra (shifts act on i_b)
//   i_funct       : R-type funct code
//   o_result      : ALU result (0 when unsupported)
//   o_supported   : 1 when i_funct is one of the implemented operations
module mips_rtype_alu
  import mips_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  input  logic [5:0]  i_funct,
  output logic [31:0] o_result,
  output logic        o_supported
);

  always_comb begin
    o_result    = '0;
    o_supported = 1'b1;
    case (i_funct)
      // add/sub wrap; overflow traps are deliberately not modelled.
      FN_ADD, FN_ADDU: o_result = i_a + i_b;
      FN_SUB, FN_SUBU: o_result = i_a - i_b;
      FN_AND:          o_result = i_a & i_b;
      FN_OR:           o_result = i_a | i_b;
      FN_XOR:          o_result = i_a ^ i_b;
      FN_NOR:          o_result = ~(i_a | i_b);
      FN_SLT:          o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
      FN_SLTU:         o_result = {31'd0, (i_a < i_b)};
      FN_SLL:          o_result = i_b << i_shamt;
      FN_SRL:          o_result = i_b >> i_shamt;
      FN_SRA:          o_result = $unsigned($signed(i_b) >>> i_shamt);
      default: begin
        o_result    = '0;
        o_supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_rtype_issuer.sv
// R-type instruction issuer driving a mips_registers-style register file.
// Accepts one instruction over valid/ready, reads rs/rt, executes on the
// ALU and writes the result to rd. One instruction per 4 cycles.
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_instr_valid/i_instr : instruction handshake input
//   o_instr_ready         : high in IDLE (registered, low during reset)
//   o_read_reg_1/2        : rs/rt read addresses (non-zero only in READ)
//   i_read_data_1/2       : combinational read data from the register file
//   o_write_reg/o_write_data/o_signal_reg_write : write port (WRITE only)
//   o_done                : one-cycle pulse when an instruction retires
//   o_illegal             : one-cycle pulse when an instruction is rejected
module mips_rtype_issuer #(
  parameter logic SKIP_R0_WRITE = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  output logic [4:0]  o_read_reg_1,
  output logic [4:0]  o_read_reg_2,
  input  logic [31:0] i_read_data_1,
  input  logic [31:0] i_read_data_2,
  output logic [4:0]  o_write_reg,
  output logic [31:0] o_write_data,
  output logic        o_signal_reg_write,
  output logic        o_done,
  output logic        o_illegal
);
  import mips_pkg::*;

  state_t      r_state;
  // Opcode is checked on the incoming word, so only the low 26 bits are kept.
  logic [25:0] r_instr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        r_instr_ready;
  logic [4:0]  r_read_reg_1;
  logic [4:0]  r_read_reg_2;
  logic [4:0]  r_write_reg;
  logic        r_reg_write;
  logic        r_done;
  logic        r_illegal;

  logic [5:0]  w_in_opcode;
  logic [4:0]  w_in_rs;
  logic [4:0]  w_in_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [31:0] w_alu_result;
  logic        w_alu_supported;

  assign w_in_opcode = i_instr[OPCODE_LSB +: OP_W];
  assign w_in_rs     = i_instr[RS_LSB +: REG_W];
  assign w_in_rt     = i_instr[RT_LSB +: REG_W];
  assign w_rd        = r_instr[RD_LSB +: REG_W];
  assign w_shamt     = r_instr[SHAMT_LSB +: REG_W];
  assign w_funct     = r_instr[FUNCT_LSB +: 6];

  // o_supported depends only on funct, so it is already valid in READ and
  // lets the illegal-funct pulse be registered into the EXEC cycle.
  mips_rtype_alu u_alu (
    .i_a         (r_a),
    .i_b         (r_b),
    .i_shamt     (w_shamt),
    .i_funct     (w_funct),
    .o_result    (w_alu_result),
    .o_supported (w_alu_supported)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_instr       <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      r_instr_ready <= 1'b0;
      r_read_reg_1  <= '0;
      r_read_reg_2  <= '0;
      r_write_reg   <= '0;
      r_reg_write   <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      // Outputs are computed for the state being entered; anything not set
      // below returns to 0, which keeps pulses one cycle wide.
      r_instr_ready <= 1'b0;
      r_read_reg_1  <= '0;
      r_read_reg_2  <= '0;
      r_write_reg   <= '0;
      r_result      <= '0;
      r_reg_write   <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_instr_valid && r_instr_ready) begin
            r_instr <= i_instr[25:0];
            if (w_in_opcode != OP_RTYPE) begin
              r_illegal     <= 1'b1;
              r_instr_ready <= 1'b1;
            end else begin
              r_state      <= ST_READ;
              r_read_reg_1 <= w_in_rs;
              r_read_reg_2 <= w_in_rt;
            end
          end else begin
            r_instr_ready <= 1'b1;
          end
        end
        ST_READ: begin
          r_a       <= i_read_data_1;
          r_b       <= i_read_data_2;
          r_state   <= ST_EXEC;
          r_illegal <= ~w_alu_supported;
        end
        ST_EXEC: begin
          if (w_alu_supported) begin
            r_result    <= w_alu_result;
            r_write_reg <= w_rd;
            r_reg_write <= ~(SKIP_R0_WRITE && (w_rd == 5'd0));
            r_done      <= 1'b1;
            r_state     <= ST_WRITE;
          end else begin
            r_state       <= ST_IDLE;
            r_instr_ready <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_state       <= ST_IDLE;
          r_instr_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_instr_ready      = r_instr_ready;
  assign o_read_reg_1       = r_read_reg_1;
  assign o_read_reg_2       = r_read_reg_2;
  assign o_write_reg        = r_write_reg;
  assign o_write_data       = r_result;
  assign o_signal_reg_write = r_reg_write;
  assign o_done             = r_done;
  assign o_illegal          = r_illegal;

endmodule

// File: tb/tb_mips_rtype_issuer.sv
module tb_mips_rtype_issuer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic        done;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    logic        is_illegal;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        wen;
    int          due;
  } exp_t;

  exp_t sb[$];

  logic [31:0] regs [32];

  mips_rtype_issuer #(.SKIP_R0_WRITE(1'b1)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_instr_valid      (instr_valid),
    .o_instr_ready      (instr_ready),
    .i_instr            (instr),
    .o_read_reg_1       (read_reg_1),
    .o_read_reg_2       (read_reg_2),
    .i_read_data_1      (read_data_1),
    .i_read_data_2      (read_data_2),
    .o_write_reg        (write_reg),
    .o_write_data       (write_data),
    .o_signal_reg_write (reg_write),
    .o_done             (done),
    .o_illegal          (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: combinational read, $0 hardwired to zero.
  assign read_data_1 = (read_reg_1 == 5'd0) ? 32'd0 : regs[read_reg_1];
  assign read_data_2 = (read_reg_2 == 5'd0) ? 32'd0 : regs[read_reg_2];
  always @(posedge clk) begin
    if (reg_write && write_reg != 5'd0) regs[write_reg] <= write_data;
  end

  function automatic logic [31:0] rt_enc(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, expv);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    regs[idx] <= v;
  endtask

  // Monitor: pops one expectation per done/illegal pulse. Cycle numbers are
  // counted from the accept edge E: the cycle right after E is E+1.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (reg_write) begin
        checks++;
        if (!done) begin
          errors++;
          $display("FAIL wen_without_done got done=%0b expected done=1", done);
        end
      end
      if (done || illegal) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got done=%0b illegal=%0b expected none", done, illegal);
        end else begin
          e = sb.pop_front();
          if (illegal !== e.is_illegal || done !== !e.is_illegal || (cyc + 1) != e.due) begin
            errors++;
            $display("FAIL %s_kind got illegal=%0b done=%0b cycle=%0d expected illegal=%0b cycle=%0d",
                     e.name, illegal, done, cyc + 1, e.is_illegal, e.due);
          end else if (!e.is_illegal &&
                       (write_reg !== e.wreg || write_data !== e.wdata || reg_write !== e.wen)) begin
            errors++;
            $display("FAIL %s_write got reg=%0d data=%08h wen=%0b expected reg=%0d data=%08h wen=%0b",
                     e.name, write_reg, write_data, reg_write, e.wreg, e.wdata, e.wen);
          end else begin
            $display("ok   %s illegal=%0b reg=%0d data=%08h wen=%0b cycle=%0d",
                     e.name, illegal, write_reg, write_data, reg_write, cyc + 1);
          end
        end
      end
    end
  end

  // Issue one instruction starting at a negedge; returns at the negedge after
  // the accept edge. keep=1 leaves instr_valid high for a back-to-back issue.
  task automatic issue(input logic [31:0] ins, input string name, input logic ill,
                       input logic [4:0] wreg, input logic [31:0] wdata, input logic wen,
                       input int lat, input bit keep, output int acc);
    exp_t e;
    int   n;
    instr_valid = 1'b1;
    instr       = ins;
    n           = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept got ready=0 expected ready=1 within 50 cycles", name);
      instr_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    e.name = name; e.is_illegal = ill; e.wreg = wreg; e.wdata = wdata; e.wen = wen;
    e.due  = acc + lat;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    if (!keep || ill) instr_valid = 1'b0;
    if (ins[31:26] == 6'h00)
      chk({name, "_read_addr"}, {54'd0, read_reg_1, read_reg_2}, {54'd0, ins[25:21], ins[20:16]});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got pending=%0d expected pending=0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    int a2;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {13'd0, instr_ready, read_reg_1, read_reg_2, write_reg, write_data,
                          reg_write, done, illegal}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, instr_ready}, 64'd1);

    // add $1,$2,$9
    preload(2, 32'd5); preload(9, 32'd7);
    issue(32'h00490820, "add", 1'b0, 5'd1, 32'd12, 1'b1, 3, 1'b0, a1);
    drain();
    chk("reg1_after_add", {32'd0, regs[1]}, 64'd12);

    // Signed vs unsigned compare, wrap-around add, shift left.
    preload(2, 32'h00000003); preload(9, 32'hFFFFFFFF);
    issue(rt_enc(2, 9, 3, 0, 6'h2A), "slt", 1'b0, 5'd3, 32'd0, 1'b1, 3, 1'b0, a1);
    issue(rt_enc(2, 9, 6, 0, 6'h2B), "sltu", 1'b0, 5'd6, 32'd1, 1'b1, 3, 1'b0, a1);
    issue(rt_enc(2, 9, 12, 0, 6'h21), "addu_wrap", 1'b0, 5'd12, 32'd2, 1'b1, 3, 1'b0, a1);
    issue(rt_enc(0, 9, 13, 31, 6'h00), "sll31", 1'b0, 5'd13, 32'h80000000, 1'b1, 3, 1'b0, a1);
    drain();
    chk("reg6_after_sltu", {32'd0, regs[6]}, 64'd1);

    // Right shifts of a negative value.
    preload(9, 32'h80000000);
    issue(rt_enc(0, 9, 4, 4, 6'h03), "sra", 1'b0, 5'd4, 32'hF8000000, 1'b1, 3, 1'b0, a1);
    issue(rt_enc(0, 9, 7, 4, 6'h02), "srl", 1'b0, 5'd7, 32'h08000000, 1'b1, 3, 1'b0, a1);
    drain();
    chk("reg4_after_sra", {32'd0, regs[4]}, 64'hF8000000);

    // rd=0 is skipped; illegal opcode and illegal funct never write.
    issue(rt_enc(2, 9, 0, 0, 6'h20), "add_r0", 1'b0, 5'd0, 32'h80000003, 1'b0, 3, 1'b0, a1);
    issue({6'h08, 5'd2, 5'd9, 5'd14, 5'd0, 6'h20}, "bad_opcode", 1'b1, 5'd0, 32'd0, 1'b0, 1, 1'b0, a1);
    issue(rt_enc(2, 9, 11, 0, 6'h3F), "bad_funct", 1'b1, 5'd0, 32'd0, 1'b0, 2, 1'b0, a1);
    drain();
    chk("reg14_untouched", {32'd0, regs[14]}, 64'd0);
    chk("reg11_untouched", {32'd0, regs[11]}, 64'd0);

    // Logic operations.
    preload(10, 32'h0F0F1234); preload(11, 32'h00FFFF00);
    issue(rt_enc(10, 11, 15, 0, 6'h24), "and", 1'b0, 5'd15, 32'h000F1200, 1'b1, 3, 1'b0, a1);
    issue(rt_enc(10, 11, 16, 0, 6'h25), "or", 1'b0, 5'd16, 32'h0FFFFF34, 1'b1, 3, 1'b0, a1);
    issue(rt_enc(10, 11, 17, 0, 6'h26), "xor", 1'b0, 5'd17, 32'h0FF0ED34, 1'b1, 3, 1'b0, a1);
    issue(rt_enc(10, 11, 18, 0, 6'h27), "nor", 1'b0, 5'd18, 32'hF00000CB, 1'b1, 3, 1'b0, a1);
    drain();
    chk("reg18_after_nor", {32'd0, regs[18]}, 64'hF00000CB);

    // Back-to-back dependent pair with instr_valid held high.
    preload(1, 32'd0); preload(2, 32'd5); preload(9, 32'd7);
    issue(32'h00490820, "b2b_add", 1'b0, 5'd1, 32'd12, 1'b1, 3, 1'b1, a1);
    issue(rt_enc(1, 2, 5, 0, 6'h22), "b2b_sub", 1'b0, 5'd5, 32'd7, 1'b1, 3, 1'b0, a2);
    chk("b2b_accept_spacing", 64'(a2 - a1), 64'd4);
    drain();
    chk("reg5_after_sub", {32'd0, regs[5]}, 64'd7);

    // Reset asserted during EXEC aborts the instruction.
    issue(rt_enc(2, 9, 8, 0, 6'h20), "aborted_add", 1'b0, 5'd8, 32'd12, 1'b1, 3, 1'b0, a1);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("outputs_in_reset", {13'd0, instr_ready, read_reg_1, read_reg_2, write_reg, write_data,
                             reg_write, done, illegal}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", {63'd0, instr_ready}, 64'd1);
    repeat (6) @(negedge clk);
    chk("reg8_not_written", {32'd0, regs[8]}, 64'd0);

    // Recovery after the abort.
    issue(rt_enc(2, 9, 19, 0, 6'h20), "add_after_reset", 1'b0, 5'd19, 32'd12, 1'b1, 3, 1'b0, a1);
    drain();
    chk("reg19_after_add", {32'd0, regs[19]}, 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
